bnn_param_loader: RTL and testbench

- Synthesizable parameter-load sequencer for the BNN datapath (conv1, conv2, fc).
- Takes a load command and a parameter data stream over valid/ready handshakes.
- Generates write strobes, memory addresses and write data for the kernel and offset memories of each layer.
- Tracks which memories are fully loaded, so the top level can gate image acceptance.

---
 rtl/bnn_pkg.sv | 47 ++++
 rtl/bnn_load_ctr.sv | 45 ++++
 rtl/bnn_param_loader.sv | 137 +++++++++++++
 tb/tb_bnn_param_loader.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types, widths and memory depths for the BNN parameter-load sequencer.
package bnn_pkg;

    localparam int DW = 25;
    localparam int OW = 9;
    localparam int AW = 11;

    localparam int K1_DEPTH = 90;
    localparam int K2_DEPTH = 1080;
    localparam int K3_DEPTH = 384;
    localparam int O1_DEPTH = 18;
    localparam int O2_DEPTH = 60;
    localparam int O3_DEPTH = 10;

    typedef enum logic [1:0] {
        L_NONE  = 2'd0,
        L_CONV1 = 2'd1,
        L_CONV2 = 2'd2,
        L_FC    = 2'd3
    } layer_e;

    typedef enum logic {
        K_KERNEL = 1'b0,
        K_OFFSET = 1'b1
    } kind_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    // One bit wider than an address so base+len can be compared without wrap.
    function automatic logic [AW:0] depth_of(input kind_e kind, input layer_e layer);
        logic [AW:0] d;
        d = '0;
        case (layer)
            L_CONV1: d = (kind == K_KERNEL) ? (AW+1)'(K1_DEPTH) : (AW+1)'(O1_DEPTH);
            L_CONV2: d = (kind == K_KERNEL) ? (AW+1)'(K2_DEPTH) : (AW+1)'(O2_DEPTH);
            L_FC:    d = (kind == K_KERNEL) ? (AW+1)'(K3_DEPTH) : (AW+1)'(O3_DEPTH);
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/bnn_load_ctr.sv
// Loadable write-address / remaining-word counter; last_o flags the final word.
module bnn_load_ctr
    import bnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic [AW-1:0] base_i,
    input  logic [AW-1:0] len_i,
    input  logic          step_i,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    logic [AW-1:0] addr_q, addr_d;
    logic [AW-1:0] rem_q, rem_d;

    always_comb begin
        // NOTE: defaults first so every path assigns both signals and no latch is inferred.
        addr_d = addr_q;
        rem_d  = rem_q;
        if (load_i) begin
            addr_d = base_i;
            rem_d  = len_i;
        end else if (step_i) begin
            addr_d = addr_q + AW'(1);
            rem_d  = rem_q - AW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking so all registers update together from pre-edge values.
        if (!rst_n) begin
            addr_q <= '0;
            rem_q  <= '0;
        end else begin
            addr_q <= addr_d;
            rem_q  <= rem_d;
        end
    end

    assign addr_o = addr_q;
    assign last_o = (rem_q == AW'(1));

endmodule

// File: rtl/bnn_param_loader.sv
// Parameter-load sequencer: turns a load command plus a word stream into
// kernel/offset memory writes and tracks which memories are fully loaded.
module bnn_param_loader
    import bnn_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_kind,
    input  logic [1:0]    cmd_layer,
    input  logic [AW-1:0] cmd_base,
    input  logic [AW-1:0] cmd_len,
    input  logic          data_valid,
    output logic          data_ready,
    input  logic [DW-1:0] data,
    input  logic          abort,
    output logic          wr_en,
    output logic          wr_kind,
    output logic [1:0]    wr_layer,
    output logic [AW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [5:0]    loaded,
    output logic          all_loaded
);

    state_e        state_q;
    kind_e         kind_q;
    layer_e        layer_q;
    logic [5:0]    loaded_q;

    logic          wr_en_q;
    kind_e         wr_kind_q;
    layer_e        wr_layer_q;
    logic [AW-1:0] wr_addr_q;
    logic [DW-1:0] wr_data_q;

    logic          cmd_hs;
    logic          data_hs;
    logic          cmd_legal;
    logic          last;
    logic [AW-1:0] addr;
    logic [AW:0]   end_addr;
    logic [2:0]    loaded_idx;
    logic [DW-1:0] wdata_fmt;

    assign cmd_ready  = (state_q == S_IDLE);
    assign data_ready = (state_q == S_LOAD) && !abort;
    assign cmd_hs     = cmd_valid && cmd_ready;
    assign data_hs    = data_valid && data_ready;

    assign end_addr  = {1'b0, cmd_base} + {1'b0, cmd_len};
    assign cmd_legal = (cmd_layer != 2'd0) && (cmd_len != '0) &&
                       (end_addr <= depth_of(kind_e'(cmd_kind), layer_e'(cmd_layer)));

    assign loaded_idx = ((kind_q == K_OFFSET) ? 3'd3 : 3'd0) + {1'b0, layer_q} - 3'd1;

    // Offsets are narrow signed values; widen them to the memory word.
    assign wdata_fmt = (kind_q == K_OFFSET) ? {{(DW-OW){data[OW-1]}}, data[OW-1:0]} : data;

    bnn_load_ctr u_ctr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (cmd_hs),
        .base_i (cmd_base),
        .len_i  (cmd_len),
        .step_i (data_hs),
        .addr_o (addr),
        .last_o (last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            kind_q   <= K_KERNEL;
            layer_q  <= L_NONE;
            loaded_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_hs) begin
                        kind_q  <= kind_e'(cmd_kind);
                        layer_q <= layer_e'(cmd_layer);
                        state_q <= cmd_legal ? S_LOAD : S_ERR;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        state_q <= S_ERR;
                    end else if (data_hs && last) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    loaded_q[loaded_idx] <= 1'b1;
                    state_q              <= S_IDLE;
                end
                S_ERR:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Write stage: one cycle behind the accepted stream word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q    <= 1'b0;
            wr_kind_q  <= K_KERNEL;
            wr_layer_q <= L_NONE;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            wr_en_q <= data_hs;
            if (data_hs) begin
                wr_kind_q  <= kind_q;
                wr_layer_q <= layer_q;
                wr_addr_q  <= addr;
                wr_data_q  <= wdata_fmt;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_kind    = wr_kind_q;
    assign wr_layer   = wr_layer_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign loaded     = loaded_q;
    assign all_loaded = &loaded_q;

endmodule

// File: tb/tb_bnn_param_loader.sv
// Directed, table-driven bench for bnn_param_loader with a write-capture monitor.
module tb_bnn_param_loader;
    import bnn_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_kind;
    logic [1:0]    cmd_layer;
    logic [AW-1:0] cmd_base;
    logic [AW-1:0] cmd_len;
    logic          data_valid;
    logic          data_ready;
    logic [DW-1:0] data;
    logic          abort;
    logic          wr_en;
    logic          wr_kind;
    logic [1:0]    wr_layer;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          err;
    logic [5:0]    loaded;
    logic          all_loaded;

    bnn_param_loader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_kind   (cmd_kind),
        .cmd_layer  (cmd_layer),
        .cmd_base   (cmd_base),
        .cmd_len    (cmd_len),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .data       (data),
        .abort      (abort),
        .wr_en      (wr_en),
        .wr_kind    (wr_kind),
        .wr_layer   (wr_layer),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .loaded     (loaded),
        .all_loaded (all_loaded)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          kind;
        logic [1:0]    layer;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic          kind;
        logic [1:0]    layer;
        logic [AW-1:0] base;
        logic [AW-1:0] len;
        bit            gaps;
        bit            exp_err;
        logic [5:0]    exp_loaded;
        bit            exp_all;
    } vec_t;

    localparam int NV = 10;

    wr_t  wq[$];
    wr_t  eq[$];
    vec_t vecs[NV];

    int n_checks = 0;
    int n_errs   = 0;
    int done_cnt = 0;
    int err_cnt  = 0;
    int viol     = 0;
    bit hs_prev  = 1'b0;

    // Capture writes and flag any write not exactly one cycle after a handshake.
    always @(negedge clk) begin
        if (!rst_n) begin
            hs_prev = 1'b0;
        end else begin
            if (wr_en !== hs_prev) viol++;
            if (done && !wr_en) viol++;
            if (wr_en) wq.push_back(wr_t'{wr_kind, wr_layer, wr_addr, wr_data});
            if (done) done_cnt++;
            if (err) err_cnt++;
            hs_prev = data_valid && data_ready;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before timeout");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] stim_word(input int i);
        if (i == 5) return 25'h0000105;
        return 25'h0AA0000 | DW'(i);
    endfunction

    function automatic logic [DW-1:0] exp_data(input logic k, input logic [DW-1:0] w);
        return k ? {{(DW-OW){w[OW-1]}}, w[OW-1:0]} : w;
    endfunction

    task automatic issue_cmd(input logic k, input logic [1:0] l,
                             input logic [AW-1:0] b, input logic [AW-1:0] n);
        bit ok;
        ok = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_kind  = k;
        cmd_layer = l;
        cmd_base  = b;
        cmd_len   = n;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                @(posedge clk); #1;
            end
        end
        cmd_valid = 1'b0;
        check("cmd_accept", 32'(ok), 32'd1);
    endtask

    task automatic feed(input logic k, input logic [1:0] l, input logic [AW-1:0] base,
                        input int first, input int n, input bit gaps);
        int acc;
        bit ok;
        acc = 0;
        for (int i = first; i < first + n; i++) begin
            ok = 1'b0;
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            data_valid = 1'b1;
            data       = stim_word(i);
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                if (data_ready) begin
                    ok = 1'b1;
                    @(posedge clk); #1;
                end
            end
            data_valid = 1'b0;
            if (!ok) break;
            acc++;
            eq.push_back(wr_t'{k, l, base + AW'(i), exp_data(k, stim_word(i))});
        end
        check("data_accept", 32'(acc), 32'(n));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int c = 0; c < 100 && !ok; c++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
        #1;
        check("idle_reached", 32'(ok), 32'd1);
    endtask

    task automatic compare_writes(input string name, input int exp_n);
        int bad;
        bad = 0;
        check({name, "_write_count"}, 32'(wq.size()), 32'(exp_n));
        for (int i = 0; i < wq.size() && i < eq.size(); i++)
            if (wq[i] !== eq[i]) bad++;
        check({name, "_write_content"}, 32'(bad), 32'd0);
        wq.delete();
        eq.delete();
    endtask

    initial begin
        int d0, e0, v0, wsz;

        vecs[0] = '{1'b1, 2'd1, 11'd0,    11'd18, 1'b0, 1'b0, 6'b001000, 1'b0};
        vecs[1] = '{1'b0, 2'd0, 11'd0,    11'd1,  1'b0, 1'b1, 6'b001000, 1'b0};
        vecs[2] = '{1'b0, 2'd1, 11'd0,    11'd0,  1'b0, 1'b1, 6'b001000, 1'b0};
        vecs[3] = '{1'b0, 2'd3, 11'd380,  11'd5,  1'b0, 1'b1, 6'b001000, 1'b0};
        vecs[4] = '{1'b1, 2'd2, 11'd1,    11'd60, 1'b0, 1'b1, 6'b001000, 1'b0};
        vecs[5] = '{1'b0, 2'd3, 11'd379,  11'd5,  1'b0, 1'b0, 6'b001100, 1'b0};
        vecs[6] = '{1'b0, 2'd1, 11'd0,    11'd90, 1'b0, 1'b0, 6'b001101, 1'b0};
        vecs[7] = '{1'b1, 2'd2, 11'd0,    11'd60, 1'b0, 1'b0, 6'b011101, 1'b0};
        vecs[8] = '{1'b1, 2'd3, 11'd0,    11'd10, 1'b0, 1'b0, 6'b111101, 1'b0};
        vecs[9] = '{1'b0, 2'd2, 11'd1000, 11'd80, 1'b1, 1'b0, 6'b111111, 1'b1};

        rst_n      = 1'b0;
        cmd_valid  = 1'b0;
        cmd_kind   = 1'b0;
        cmd_layer  = 2'd0;
        cmd_base   = '0;
        cmd_len    = '0;
        data_valid = 1'b0;
        data       = '0;
        abort      = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready",  32'(cmd_ready),  32'd1);
        check("rst_data_ready", 32'(data_ready), 32'd0);
        check("rst_busy",       32'(busy),       32'd0);
        check("rst_done_err",   32'({done, err}), 32'd0);
        check("rst_wr_en",      32'(wr_en),      32'd0);
        check("rst_wr_addr",    32'(wr_addr),    32'd0);
        check("rst_wr_data",    32'(wr_data),    32'd0);
        check("rst_loaded",     32'(loaded),     32'd0);
        check("rst_all_loaded", 32'(all_loaded), 32'd0);
        #2 rst_n = 1'b1;

        // Abort an fc kernel load after four accepted words.
        d0 = done_cnt; e0 = err_cnt; v0 = viol;
        issue_cmd(1'b0, 2'd3, 11'd0, 11'd10);
        @(negedge clk);
        @(posedge clk); #1;
        feed(1'b0, 2'd3, 11'd0, 0, 4, 1'b0);
        abort      = 1'b1;
        data_valid = 1'b1;
        data       = stim_word(4);
        @(negedge clk);
        check("abort_blocks_data", 32'(data_ready), 32'd0);
        @(posedge clk); #1;
        abort      = 1'b0;
        data_valid = 1'b0;
        @(negedge clk);
        check("abort_err_pulse", 32'({err, done}), 32'b10);
        wait_idle();
        check("abort_loaded",     32'(loaded),        32'd0);
        check("abort_done_count", 32'(done_cnt - d0), 32'd0);
        check("abort_err_count",  32'(err_cnt - e0),  32'd1);
        check("abort_latency",    32'(viol - v0),     32'd0);
        compare_writes("abort", 4);

        for (int v = 0; v < NV; v++) begin
            d0 = done_cnt; e0 = err_cnt; v0 = viol;
            issue_cmd(vecs[v].kind, vecs[v].layer, vecs[v].base, vecs[v].len);
            @(negedge clk);
            if (vecs[v].exp_err) begin
                check($sformatf("v%0d_err_pulse", v), 32'({err, busy}), 32'b11);
            end else begin
                check($sformatf("v%0d_load_ready", v), 32'(data_ready), 32'd1);
                @(posedge clk); #1;
                feed(vecs[v].kind, vecs[v].layer, vecs[v].base, 0, int'(vecs[v].len), vecs[v].gaps);
                @(negedge clk);
                check($sformatf("v%0d_done_with_last_write", v), 32'({done, wr_en}), 32'b11);
                check($sformatf("v%0d_all_loaded_in_done", v), 32'(all_loaded), 32'd0);
            end
            wait_idle();
            check($sformatf("v%0d_loaded", v),     32'(loaded),        32'(vecs[v].exp_loaded));
            check($sformatf("v%0d_all_loaded", v), 32'(all_loaded),    32'(vecs[v].exp_all));
            check($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), vecs[v].exp_err ? 32'd0 : 32'd1);
            check($sformatf("v%0d_err_count", v),  32'(err_cnt - e0),  vecs[v].exp_err ? 32'd1 : 32'd0);
            check($sformatf("v%0d_latency", v),    32'(viol - v0),     32'd0);
            if (v == 0)
                check("v0_word5_sign_ext", (wq.size() > 5) ? 32'(wq[5].data) : 32'hDEAD_BEEF, 32'h1FFFF05);
            compare_writes($sformatf("v%0d", v), vecs[v].exp_err ? 0 : int'(vecs[v].len));
        end

        // Back-to-back: second command held valid through DONE of the first.
        d0 = done_cnt; v0 = viol;
        issue_cmd(1'b1, 2'd1, 11'd0, 11'd3);
        @(negedge clk);
        @(posedge clk); #1;
        feed(1'b1, 2'd1, 11'd0, 0, 2, 1'b0);
        cmd_valid = 1'b1;
        cmd_kind  = 1'b0;
        cmd_layer = 2'd1;
        cmd_base  = 11'd10;
        cmd_len   = 11'd2;
        feed(1'b1, 2'd1, 11'd0, 2, 1, 1'b0);
        @(negedge clk);
        check("b2b_done_not_ready", 32'({done, cmd_ready}), 32'b10);
        @(negedge clk);
        check("b2b_first_idle", 32'({cmd_ready, busy, wr_en}), 32'b100);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("b2b_second_load", 32'({busy, data_ready}), 32'b11);
        @(posedge clk); #1;
        feed(1'b0, 2'd1, 11'd10, 0, 2, 1'b0);
        wait_idle();
        check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
        check("b2b_latency",    32'(viol - v0),     32'd0);
        check("b2b_loaded",     32'(loaded),        32'h3F);
        compare_writes("b2b", 5);

        // Asynchronous reset in the middle of a load.
        issue_cmd(1'b0, 2'd1, 11'd0, 11'd5);
        @(negedge clk);
        @(posedge clk); #1;
        feed(1'b0, 2'd1, 11'd0, 0, 2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_loaded", 32'({loaded, all_loaded}), 32'd0);
        check("rst_async_state",  32'({busy, wr_en, cmd_ready}), 32'b001);
        #2 rst_n = 1'b1;
        wsz = wq.size();
        @(posedge clk); #1;
        data_valid = 1'b1;
        data       = stim_word(2);
        @(negedge clk);
        check("rst_no_resume", 32'({busy, data_ready}), 32'b00);
        repeat (2) @(posedge clk);
        #1 data_valid = 1'b0;
        @(negedge clk);
        check("rst_no_write", 32'(wq.size()), 32'(wsz));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
